// File: rtl/impact_sram_sequencer_pkg.sv
// Shared definitions for the IMPACT SRAM sequencer: FSM state encoding, default widths and phase lengths.
package impact_sram_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRECH  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_PRE_CYCLES = 2;
    localparam int DEF_ACC_CYCLES = 2;

    // Counter must hold the longer of the two phase lengths minus one.
    function automatic int phase_cnt_w(input int pre_cycles, input int acc_cycles);
        int longest;
        longest = (pre_cycles > acc_cycles) ? pre_cycles : acc_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/impact_phase_timer.sv
// Load / count-down / zero-flag timer shared by the PRECH and ACCESS phases of the SRAM sequencer.
module impact_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/impact_sram_sequencer.sv
// IMPACT head / SRAM bank timing sequencer: PRE -> ReadEn/WriteEn -> response, all strobes registered.
// Optional access statistics enabled by defining IMPACT_SEQ_STATS_EN.
module impact_sram_sequencer
    import impact_sram_sequencer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PRE_CYCLES = DEF_PRE_CYCLES,
    parameter int ACC_CYCLES = DEF_ACC_CYCLES
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_pre,
    output logic              sram_rd_en,
    output logic              sram_wr_en,
    output logic [DATA_W-1:0] sram_din,
`ifdef IMPACT_SEQ_STATS_EN
    output logic [15:0]       stat_reads,
    output logic [15:0]       stat_writes,
`endif
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int CNT_W = phase_cnt_w(PRE_CYCLES, ACC_CYCLES);

    seq_state_e       state;
    logic             write_q;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = CNT_W'(PRE_CYCLES - 1);
        if (accept) begin
            tmr_load = 1'b1;
        end else if (state == ST_PRECH && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(ACC_CYCLES - 1);
        end
    end

    impact_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            write_q    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            sram_pre   <= 1'b0;
            sram_rd_en <= 1'b0;
            sram_wr_en <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_PRECH;
                        write_q   <= req_write;
                        sram_addr <= req_addr;
                        sram_din  <= req_wdata;
                        sram_pre  <= 1'b1;
                    end
                end
                ST_PRECH: begin
                    if (tmr_zero) begin
                        state      <= ST_ACCESS;
                        sram_pre   <= 1'b0;
                        sram_rd_en <= !write_q;
                        sram_wr_en <= write_q;
                    end
                end
                ST_ACCESS: begin
                    // Bank data is sampled on the edge that closes the access window.
                    if (tmr_zero) begin
                        state      <= ST_DONE;
                        sram_rd_en <= 1'b0;
                        sram_wr_en <= 1'b0;
                        rsp_valid  <= 1'b1;
                        if (!write_q) begin
                            rsp_rdata <= sram_dout;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IMPACT_SEQ_STATS_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else if (state == ST_DONE) begin
            if (write_q && stat_writes != 16'hFFFF) begin
                stat_writes <= stat_writes + 16'd1;
            end
            if (!write_q && stat_reads != 16'hFFFF) begin
                stat_reads <= stat_reads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_impact_sram_sequencer.sv
// Scoreboard bench for impact_sram_sequencer: directed requests push expectations, a negedge monitor checks.
module tb_impact_sram_sequencer;
    import impact_sram_sequencer_pkg::*;

    localparam int PRE = DEF_PRE_CYCLES;
    localparam int ACC = DEF_ACC_CYCLES;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [9:0]  sram_addr;
    logic        sram_pre;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;
`ifdef IMPACT_SEQ_STATS_EN
    logic [15:0] stat_reads;
    logic [15:0] stat_writes;
`endif

    exp_t exp_q[$];
    vec_t vecs[5];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   mon_k;
    logic [4:0] mon_exp;

    impact_sram_sequencer dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_addr  (sram_addr),
        .sram_pre   (sram_pre),
        .sram_rd_en (sram_rd_en),
        .sram_wr_en (sram_wr_en),
        .sram_din   (sram_din),
`ifdef IMPACT_SEQ_STATS_EN
        .stat_reads (stat_reads),
        .stat_writes(stat_writes),
`endif
        .sram_dout  (sram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: address-dependent data while ReadEn is high, junk otherwise.
    function automatic logic [31:0] dout_of(input logic [9:0] a);
        if (a == 10'h005) return 32'hA5A5_5A5A;
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    assign sram_dout = sram_rd_en ? dout_of(sram_addr) : 32'h0BAD_0BAD;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: {pre, rd_en, wr_en, rsp_valid, req_ready} against the phase model of the oldest request.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp = 5'b00001;
            mon_k   = 0;
            if (exp_q.size() != 0) begin
                mon_k = cyc - exp_q[0].acc;
                mon_exp = {(mon_k >= 1 && mon_k <= PRE),
                           (!exp_q[0].wr && mon_k > PRE && mon_k <= PRE + ACC),
                           (exp_q[0].wr && mon_k > PRE && mon_k <= PRE + ACC),
                           (mon_k == PRE + ACC + 1),
                           1'b0};
                check("sram_addr", 64'(sram_addr), 64'(exp_q[0].addr));
                check("sram_din", 64'(sram_din), 64'(exp_q[0].data));
            end
            check("strobes", 64'({sram_pre, sram_rd_en, sram_wr_en, rsp_valid, req_ready}), 64'(mon_exp));
            if (exp_q.size() != 0) begin
                if (rsp_valid) begin
                    check("rsp_latency", 64'(mon_k), 64'(PRE + ACC + 1));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
                    void'(exp_q.pop_front());
                end else if (mon_k > PRE + ACC + 1) begin
                    check("rsp_timeout", 64'(rsp_valid), 64'(1));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [9:0] a, input logic [31:0] d,
                          input logic [31:0] er, input bit hold, output int acc);
        int w;
        w   = 0;
        acc = -1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 64'(req_ready), 64'(1));
        if (req_ready) begin
            acc = cyc;
            @(posedge clk);
            #1;
            exp_q.push_back('{wr: wr, addr: a, data: d, rdata: er, acc: acc});
        end
        if (!hold || acc < 0) req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_a;
        int acc_b;
        int w;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_strobes", 64'({sram_pre, sram_rd_en, sram_wr_en, rsp_valid}), 64'(0));
        check("reset_ready", 64'(req_ready), 64'(1));
        check("reset_rdata", 64'(rsp_rdata), 64'(0));
        check("reset_addr_din", 64'({sram_addr, sram_din}), 64'(0));
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Write to the top address; rsp_rdata stays at its reset value.
        do_req(1'b1, 10'h3FF, 32'hDEAD_BEEF, 32'h0, 1'b0, acc_a);
        drain();

        // Single read.
        do_req(1'b0, 10'h005, 32'h0, 32'hA5A5_5A5A, 1'b0, acc_a);
        drain();

        // Two reads with req_valid held continuously.
        do_req(1'b0, 10'h100, 32'h0, 32'hC0DE_0100, 1'b1, acc_a);
        do_req(1'b0, 10'h200, 32'h0, 32'hC0DE_0200, 1'b0, acc_b);
        check("accept_spacing", 64'(acc_b - acc_a), 64'(PRE + ACC + 2));
        drain();

        // Reset during the ACCESS phase of a write.
        do_req(1'b1, 10'h0AA, 32'h1122_3344, 32'hC0DE_0200, 1'b0, acc_a);
        w = 0;
        while (!sram_wr_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("wr_en_reached", 64'(sram_wr_en), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("abort_wr_en", 64'(sram_wr_en), 64'(0));
        check("abort_rdata", 64'(rsp_rdata), 64'(0));
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;

        // Recovery batch: three writes and two reads.
        vecs[0] = '{wr: 1'b1, addr: 10'h001, data: 32'h0000_0001, rdata: 32'h0};
        vecs[1] = '{wr: 1'b1, addr: 10'h3FE, data: 32'hFFFF_FFFF, rdata: 32'h0};
        vecs[2] = '{wr: 1'b0, addr: 10'h0AA, data: 32'h0000_0000, rdata: 32'hC0DE_00AA};
        vecs[3] = '{wr: 1'b1, addr: 10'h000, data: 32'h0000_0000, rdata: 32'hC0DE_00AA};
        vecs[4] = '{wr: 1'b0, addr: 10'h3FF, data: 32'h5555_AAAA, rdata: 32'hC0DE_03FF};
        for (int i = 0; i < 5; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rdata, 1'b0, acc_a);
        end
        drain();

`ifdef IMPACT_SEQ_STATS_EN
        check("stat_writes", 64'(stat_writes), 64'(3));
        check("stat_reads", 64'(stat_reads), 64'(2));
`endif

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
